// File: rtl/pong_pkg.sv
// Shared Pong definitions: paddle FSM states and playfield geometry.
// Used by paddle control, ball/collision and VGA draw logic.
// Pure declarations, no logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    CENTER = 2'd2
  } paddle_state_t;

  localparam int SCREEN_H = 480;
  localparam int PADDLE_H = 80;
  localparam int INIT_Y   = 200;

endpackage

// File: rtl/paddle_ctrl_pend_queue.sv
// Saturating signed press counter: +1 on inc, -1 on dec, optional step toward zero.
// Latency: one cycle; pend reflects inputs of the previous edge.
// No backpressure: pulses beyond +/-QDEPTH or while discarding are dropped.
module pend_queue
  import pong_pkg::*;
#(
  parameter int QDEPTH = 3,
  parameter int P_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc,
  input  logic           dec,
  input  logic           discard,
  input  logic           step,
  input  logic           clear,
  output logic [P_W-1:0] pend
);

  // Two guard bits so step plus a press never overflows before saturation.
  localparam int S_W = P_W + 2;
  localparam logic signed [S_W-1:0] ONE  = S_W'(1);
  localparam logic signed [S_W-1:0] QMAX = S_W'(QDEPTH);
  localparam logic signed [S_W-1:0] QMIN = -QMAX;

  logic signed [S_W-1:0] sum;
  logic [P_W-1:0]        pend_nxt;
  logic                  neg;
  logic                  nz;

  assign neg = pend[P_W-1];
  assign nz  = |pend;

  // Next count: step toward zero first, then net press effect, then saturate.
  always_comb begin
    sum = $signed({{(S_W-P_W){pend[P_W-1]}}, pend});
    if (step) begin
      if (neg) begin
        sum = sum + ONE;
      end else if (nz) begin
        sum = sum - ONE;
      end
    end
    // Simultaneous up and down cancel; nothing counts while discarding.
    if (!discard && inc && !dec) begin
      sum = sum + ONE;
    end else if (!discard && dec && !inc) begin
      sum = sum - ONE;
    end
    if (sum > QMAX) begin
      sum = QMAX;
    end else if (sum < QMIN) begin
      sum = QMIN;
    end
    pend_nxt = clear ? '0 : sum[P_W-1:0];
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position animator: queued button presses become 1 px/frame moves, clamped.
// Latency: press at n -> pend at n+1 -> MOVE at n+2; pixels move on frame_tick in MOVE.
// No backpressure: excess presses saturate the queue and are dropped.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H = pong_pkg::SCREEN_H,
  parameter int PADDLE_H = pong_pkg::PADDLE_H,
  parameter int STEP     = 32,
  parameter int INIT_Y   = pong_pkg::INIT_Y,
  parameter int Y_W      = 10,
  parameter int QDEPTH   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic           up_p,
  input  logic           down_p,
  input  logic           freeze,
  input  logic           recenter,
  output logic [Y_W-1:0] paddle_y,
  output logic           moving,
  output logic [3:0]     pend
);

  localparam int R_W = $clog2(STEP + 1);
  localparam logic [R_W-1:0] R_STEP = R_W'(STEP);
  localparam logic [R_W-1:0] R_ONE  = R_W'(1);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W-1:0] Y_HOME = Y_W'(INIT_Y);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

  paddle_state_t  state;
  logic [R_W-1:0] remain;
  logic           dir;       // 1 = up (y decreasing), 0 = down
  logic           tick_ok;
  logic           at_bound;
  logic           load;
  logic           abort;
  logic           q_clear;
  logic           q_discard;

  // Frame ticks only count while not frozen.
  assign tick_ok  = frame_tick && !freeze;

  // Paddle already touching the edge it is heading toward.
  assign at_bound = dir ? (paddle_y == '0) : (paddle_y == Y_MAX);

  // Pull the next queued move out of the counter.
  assign load     = (state == IDLE) && !recenter && (pend != '0) && !freeze;

  // Move cut short at the playfield edge; the rest of the queue is thrown away.
  assign abort    = (state == MOVE) && !recenter && tick_ok && at_bound;

  assign q_clear   = recenter || abort;
  assign q_discard = freeze || (state == CENTER);

  pend_queue #(
    .QDEPTH (QDEPTH),
    .P_W    (4)
  ) u_pend_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (down_p),
    .dec     (up_p),
    .discard (q_discard),
    .step    (load),
    .clear   (q_clear),
    .pend    (pend)
  );

  // Motion FSM with remain counter, position register and registered moving flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      remain   <= '0;
      dir      <= 1'b0;
      paddle_y <= Y_HOME;
      moving   <= 1'b0;
    end else if (recenter) begin
      // Recenter overrides everything, even freeze and an ongoing recenter.
      state    <= CENTER;
      remain   <= '0;
      moving   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state  <= MOVE;
            remain <= R_STEP;
            dir    <= pend[3];
            moving <= 1'b1;
          end
        end
        MOVE: begin
          if (tick_ok) begin
            if (at_bound) begin
              state  <= IDLE;
              remain <= '0;
              moving <= 1'b0;
            end else begin
              paddle_y <= dir ? (paddle_y - Y_ONE) : (paddle_y + Y_ONE);
              remain   <= remain - R_ONE;
              if (remain == R_ONE) begin
                state  <= IDLE;
                moving <= 1'b0;
              end
            end
          end
        end
        CENTER: begin
          // Frozen: hold both state and position until play resumes.
          if (!freeze) begin
            if (paddle_y == Y_HOME) begin
              state  <= IDLE;
              moving <= 1'b0;
            end else if (frame_tick) begin
              paddle_y <= (paddle_y < Y_HOME) ? (paddle_y + Y_ONE) : (paddle_y - Y_ONE);
            end
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule
